// File: rtl/data_mem_access_unit_pkg.sv
// data_mem_access_unit_pkg: size encodings, FSM states and lane masks for the Data_mem initiator
package data_mem_access_unit_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
  localparam logic [31:0] HALF_MASK = 32'h0000_ffff;
  localparam logic [31:0] WORD_MASK = 32'hffff_ffff;
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, MERGE, WR, RESP} state_t;
  function automatic logic is_fault(input logic [1:0] size, input logic [1:0] lo);
    return size == SZ_ILL || (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
  endfunction
endpackage

// File: rtl/data_mem_access_unit_lane_align.sv
// mem_lane_align: little-endian load extract/extend and sub-word store merge
module mem_lane_align
  import data_mem_access_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);
  logic [4:0]  sh;
  logic [31:0] shr;
  logic [31:0] mask;
  assign sh      = size == SZ_HALF ? {addr_lo[1], 4'b0} : {addr_lo, 3'b0};
  assign shr     = rword >> sh;
  assign ld_data = size == SZ_BYTE ? {{24{sgn & shr[7]}}, shr[7:0]} :
                   size == SZ_HALF ? {{16{sgn & shr[15]}}, shr[15:0]} : rword;
  assign mask    = (size == SZ_BYTE ? BYTE_MASK : size == SZ_HALF ? HALF_MASK : WORD_MASK) << sh;
  assign st_data = (rword & ~mask) | ((wdata << sh) & mask);
endmodule

// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: one-at-a-time load/store sequencer driving the Data_mem strobes
module data_mem_access_unit
  import data_mem_access_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req_valid,
  output logic              Req_ready,
  input  logic              Req_we,
  input  logic [1:0]        Req_size,
  input  logic              Req_signed,
  input  logic [ADDR_W-1:0] Req_addr,
  input  logic [DATA_W-1:0] Req_wdata,
  output logic              Rsp_valid,
  output logic [DATA_W-1:0] Rsp_rdata,
  output logic              Rsp_fault,
  output logic [ADDR_W-1:0] Mem_address,
  output logic [DATA_W-1:0] Mem_data_in,
  output logic              Mem_we,
  output logic              Mem_re,
  input  logic [DATA_W-1:0] Mem_data_out
);
  localparam int CW = $clog2(READ_LAT + 1);
  state_t            state;
  logic [CW-1:0]     cnt;
  logic              r_we;
  logic              r_sgn;
  logic [1:0]        r_size;
  logic [1:0]        r_lo;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_data;
  mem_lane_align u_align (
    .addr_lo (r_lo),
    .size    (r_size),
    .sgn     (r_sgn),
    .rword   (state == MERGE ? word : Mem_data_out),
    .wdata   (r_wdata),
    .ld_data (ld_data),
    .st_data (st_data)
  );
  // Request sequencing: every output is updated here so all of them come straight from flops
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      r_we        <= 1'b0;
      r_sgn       <= 1'b0;
      r_size      <= SZ_BYTE;
      r_lo        <= 2'b00;
      r_wdata     <= '0;
      word        <= '0;
      Req_ready   <= 1'b0;
      Rsp_valid   <= 1'b0;
      Rsp_rdata   <= '0;
      Rsp_fault   <= 1'b0;
      Mem_address <= '0;
      Mem_data_in <= '0;
      Mem_we      <= 1'b0;
      Mem_re      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Req_ready <= !(Req_valid && Req_ready);
          if (Req_valid && Req_ready) begin
            r_we    <= Req_we;
            r_sgn   <= Req_signed;
            r_size  <= Req_size;
            r_lo    <= Req_addr[1:0];
            r_wdata <= Req_wdata;
            if (is_fault(Req_size, Req_addr[1:0])) begin
              state     <= RESP;
              Rsp_valid <= 1'b1;
              Rsp_fault <= 1'b1;
              Rsp_rdata <= '0;
            end else if (Req_we && Req_size == SZ_WORD) begin
              state       <= WR;
              Mem_we      <= 1'b1;
              Mem_address <= {Req_addr[ADDR_W-1:2], 2'b00};
              Mem_data_in <= Req_wdata;
            end else begin
              state       <= RD;
              Mem_re      <= 1'b1;
              Mem_address <= {Req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        RD: begin
          Mem_re <= 1'b0;
          cnt    <= CW'(READ_LAT);
          state  <= RD_WAIT;
        end
        RD_WAIT: begin
          if (cnt == CW'(1)) begin
            word <= Mem_data_out;
            if (r_we) state <= MERGE;
            else begin
              state     <= RESP;
              Rsp_valid <= 1'b1;
              Rsp_rdata <= ld_data;
            end
          end else cnt <= cnt - CW'(1);
        end
        MERGE: begin
          Mem_data_in <= st_data;
          Mem_we      <= 1'b1;
          state       <= WR;
        end
        WR: begin
          Mem_we    <= 1'b0;
          Rsp_valid <= 1'b1;
          Rsp_rdata <= '0;
          state     <= RESP;
        end
        RESP: begin
          Rsp_valid <= 1'b0;
          Rsp_fault <= 1'b0;
          Rsp_rdata <= '0;
          Req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
